ram_ctrl: RTL

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_pkg.sv | 9 +
 rtl/ram_ctrl_if.sv | 16 +
 rtl/ram_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths, SRAM op codes and controller state enum
package ram_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH = 8;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: host request/response + SRAM strobe bus; slave = controller, master = host/SRAM side
interface ram_ctrl_if;
  import ram_ctrl_pkg::*;
  logic req_valid, req_ready, req_op, req_clear;
  logic [ADDR_W-1:0] req_addr, ram_addr;
  logic [DATA_W-1:0] req_data, rsp_data, ram_inp, ram_outp;
  logic rsp_valid, clear_done, ram_op, ram_sel;
  modport slave(
    input req_valid, req_op, req_addr, req_data, req_clear, ram_outp,
    output req_ready, rsp_valid, rsp_data, clear_done, ram_inp, ram_addr, ram_op, ram_sel
  );
  modport master(
    output req_valid, req_op, req_addr, req_data, req_clear, ram_outp,
    input req_ready, rsp_valid, rsp_data, clear_done, ram_inp, ram_addr, ram_op, ram_sel
  );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: SETUP/STROBE/HOLD SRAM access sequencer with 8-word clear; ports clk, rst, bus (ram_ctrl_if.slave)
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input logic clk,
  input logic rst,
  ram_ctrl_if.slave bus
);
  state_t state;
  logic clearing;
  logic [ADDR_W-1:0] cnt;
  logic sel_q;
  assign bus.req_ready = (state == IDLE) && !rst;
  // rst kills the strobe in the same cycle so an aborted access never commits to the SRAM
  assign bus.ram_sel = sel_q && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      clearing <= 1'b0;
      cnt <= '0;
      sel_q <= 1'b0;
      bus.ram_op <= OP_READ;
      bus.ram_addr <= '0;
      bus.ram_inp <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.clear_done <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.clear_done <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          state <= SETUP;
          clearing <= bus.req_clear;
          cnt <= '0;
          bus.ram_addr <= bus.req_clear ? '0 : bus.req_addr;
          bus.ram_inp <= bus.req_clear ? CLEAR_VALUE : bus.req_data;
          bus.ram_op <= bus.req_clear ? OP_WRITE : bus.req_op;
        end
        SETUP: begin
          state <= STROBE;
          sel_q <= 1'b1;
        end
        STROBE: begin
          state <= HOLD;
          sel_q <= 1'b0;
          if (bus.ram_op == OP_READ) begin
            bus.rsp_data <= bus.ram_outp;
            bus.rsp_valid <= 1'b1;
          end
        end
        HOLD: if (clearing && cnt != ADDR_W'(DEPTH - 1)) begin
          state <= SETUP;
          cnt <= cnt + 1'b1;
          bus.ram_addr <= cnt + 1'b1;
        end else begin
          state <= IDLE;
          bus.clear_done <= clearing;
          clearing <= 1'b0;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule
